lcd_hd44780_responder: RTL and testbench

LCD_HD44780_RESPONDER -- requirements
Module: lcd_hd44780_responder

---
 rtl/lcd_hd44780_responder_if.sv | 21 ++
 rtl/lcd_hd44780_responder.sv | 218 +++++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/lcd_hd44780_responder_if.sv
// rtl/lcd_hd44780_responder_if.sv - host-side HD44780 LCD pin bundle
interface lcd_hd44780_responder_if;
  logic [7:0] lcd_DATA_in;
  logic [7:0] lcd_DATA_out;
  logic       lcd_DATA_oe;
  logic       lcd_EN;
  logic       lcd_RS;
  logic       lcd_RW;
  logic       lcd_ON;
  logic       lcd_BLON;

  modport master (
    output lcd_DATA_in, lcd_EN, lcd_RS, lcd_RW, lcd_ON, lcd_BLON,
    input  lcd_DATA_out, lcd_DATA_oe
  );

  modport slave (
    input  lcd_DATA_in, lcd_EN, lcd_RS, lcd_RW, lcd_ON, lcd_BLON,
    output lcd_DATA_out, lcd_DATA_oe
  );
endinterface

// File: rtl/lcd_hd44780_responder.sv
// rtl/lcd_hd44780_responder.sv - HD44780 controller model: 2x16 DDRAM, busy timing, host bus responder
module lcd_hd44780_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 80000
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  lcd_hd44780_responder_if.slave  lcd,
  input  logic [4:0]              view_addr,
  output logic [7:0]              view_char,
  output logic                    busy,
  output logic                    disp_on,
  output logic [6:0]              ddram_addr,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, CLEARING, BUSY} state_t;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [4:0]  clr_idx, clr_idx_n;
  logic        clr_tail, clr_tail_n;
  logic        init_pending, init_pending_n;

  logic [10:0] s1, s2, s3;
  logic [6:0]  ac;
  logic        id, disp, cg_mode;
  logic [7:0]  mem [32];

  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [7:0]  mem_wdata;

  // Stage packing: {EN, RS, RW, DATA}
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {lcd.lcd_EN, lcd.lcd_RS, lcd.lcd_RW, lcd.lcd_DATA_in};
      s2 <= s1;
      s3 <= s2;
    end
  end

  logic       sy_en, sy_rs, sy_rw, x_en, x_rs, x_rw;
  logic [7:0] x_data;
  assign sy_en  = s2[10];
  assign sy_rs  = s2[9];
  assign sy_rw  = s2[8];
  assign x_en   = s3[10];
  assign x_rs   = s3[9];
  assign x_rw   = s3[8];
  assign x_data = s3[7:0];

  logic en_fall, wr_fall, rd_data_fall, accept, reject, is_clear, is_home;
  assign en_fall      = !sy_en && x_en;
  assign wr_fall      = en_fall && !x_rw;
  assign rd_data_fall = en_fall && x_rw && x_rs;
  assign accept       = wr_fall && (state == IDLE) && !init_pending;
  assign reject       = wr_fall && !accept;
  assign is_clear     = !x_rs && (x_data == 8'h01);
  assign is_home      = !x_rs && (x_data[7:1] == 7'b0000001);

  logic       ac_ok;
  logic [4:0] ac_cell;
  always_comb begin
    ac_ok   = 1'b0;
    ac_cell = {1'b0, ac[3:0]};
    if (ac[6:4] == 3'b000) begin
      ac_ok = 1'b1;
    end else if (ac[6:4] == 3'b100) begin
      ac_ok   = 1'b1;
      ac_cell = {1'b1, ac[3:0]};
    end
  end

  // Two 40-character lines: 0x00-0x27 and 0x40-0x67, wrapping into each other
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h27)      ac_step = 7'h40;
      else if (a == 7'h67) ac_step = 7'h00;
      else                 ac_step = a + 7'd1;
    end else begin
      if (a == 7'h00)      ac_step = 7'h67;
      else if (a == 7'h40) ac_step = 7'h27;
      else                 ac_step = a - 7'd1;
    end
  endfunction

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      clr_idx      <= '0;
      clr_tail     <= 1'b0;
      init_pending <= 1'b1;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      clr_idx      <= clr_idx_n;
      clr_tail     <= clr_tail_n;
      init_pending <= init_pending_n;
    end
  end

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    clr_idx_n      = clr_idx;
    clr_tail_n     = clr_tail;
    init_pending_n = init_pending;
    case (state)
      IDLE: begin
        if (init_pending) begin
          state_n        = CLEARING;
          clr_idx_n      = '0;
          clr_tail_n     = 1'b0;
          init_pending_n = 1'b0;
        end else if (accept) begin
          if (is_clear) begin
            state_n    = CLEARING;
            clr_idx_n  = '0;
            clr_tail_n = 1'b1;
          end else begin
            state_n = BUSY;
            cnt_n   = is_home ? 32'(CLEAR_CYCLES - 1) : 32'(BUSY_CYCLES - 1);
          end
        end
      end
      CLEARING: begin
        clr_idx_n = clr_idx + 5'd1;
        if (clr_idx == 5'd31) begin
          if (clr_tail) begin
            state_n = BUSY;
            cnt_n   = 32'(CLEAR_CYCLES - 33);
          end else begin
            state_n = IDLE;
          end
        end
      end
      BUSY: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 32'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ac      <= '0;
      id      <= 1'b1;
      disp    <= 1'b0;
      cg_mode <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (reject) err <= 1'b1;
      if (accept && !x_rs) begin
        casez (x_data)
          8'b1???????: begin ac <= x_data[6:0]; cg_mode <= 1'b0; end
          8'b01??????: cg_mode <= 1'b1;
          8'b001?????: if (!x_data[4]) err <= 1'b1;
          8'b00001???: disp <= x_data[2];
          8'b000001??: id <= x_data[1];
          8'b0000001?: ac <= '0;
          8'b00000001: begin ac <= '0; id <= 1'b1; end
          default: ;
        endcase
      end else if ((accept && x_rs) || rd_data_fall) begin
        ac <= ac_step(ac, id);
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_idx;
    mem_wdata = 8'h20;
    if (state == CLEARING) begin
      mem_we = 1'b1;
    end else if (accept && x_rs && !cg_mode && ac_ok) begin
      mem_we    = 1'b1;
      mem_waddr = ac_cell;
      mem_wdata = x_data;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Forward a same-cycle write so the inspection port never shows stale data
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)
      view_char <= 8'h20;
    else if (mem_we && (mem_waddr == view_addr))
      view_char <= mem_wdata;
    else
      view_char <= mem[view_addr];
  end

  always_comb begin
    if (sy_rs) lcd.lcd_DATA_out = ac_ok ? mem[ac_cell] : 8'h20;
    else       lcd.lcd_DATA_out = {busy, ac};
  end

  assign lcd.lcd_DATA_oe = sy_en && sy_rw;
  assign disp_on         = disp && lcd.lcd_ON;
  assign ddram_addr      = ac;

  logic unused_blon;
  assign unused_blon = lcd.lcd_BLON;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb/tb_lcd_hd44780_responder.sv - directed bench for lcd_hd44780_responder
module tb_lcd_hd44780_responder;
  localparam int BC = 20;
  localparam int CC = 60;

  logic       clk;
  logic       rst_n;
  logic [4:0] view_addr;
  logic [7:0] view_char;
  logic       busy, disp_on, err;
  logic [6:0] ddram_addr;

  int checks   = 0;
  int failures = 0;

  lcd_hd44780_responder_if bus ();

  lcd_hd44780_responder #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .lcd           (bus.slave),
    .view_addr     (view_addr),
    .view_char     (view_char),
    .busy          (busy),
    .disp_on       (disp_on),
    .ddram_addr    (ddram_addr),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lcd_wr(input logic rs, input logic [7:0] d);
    bus.lcd_RS      = rs;
    bus.lcd_RW      = 1'b0;
    bus.lcd_DATA_in = d;
    bus.lcd_EN      = 1'b1;
    idle(4);
    bus.lcd_EN = 1'b0;
    idle(4);
  endtask

  task automatic lcd_rd(input logic rs, output logic [7:0] d, output logic oe);
    bus.lcd_RS = rs;
    bus.lcd_RW = 1'b1;
    bus.lcd_EN = 1'b1;
    idle(4);
    d  = bus.lcd_DATA_out;
    oe = bus.lcd_DATA_oe;
    bus.lcd_EN = 1'b0;
    idle(4);
    bus.lcd_RW = 1'b0;
  endtask

  task automatic view(input logic [4:0] a, output logic [7:0] v);
    view_addr = a;
    idle(2);
    v = view_char;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic       oe;
    rst_n = 1'b0;
    view_addr = 5'd0;
    bus.lcd_DATA_in = 8'h00;
    bus.lcd_EN = 1'b0;
    bus.lcd_RS = 1'b0;
    bus.lcd_RW = 1'b0;
    bus.lcd_ON = 1'b1;
    bus.lcd_BLON = 1'b1;
    idle(3);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ac", ddram_addr, 0);
    chk("rst_oe", bus.lcd_DATA_oe, 0);
    chk("rst_dout", bus.lcd_DATA_out, 8'h00);
    chk("rst_view", view_char, 8'h20);
    chk("rst_disp", disp_on, 0);

    rst_n = 1'b1;
    idle(3);
    chk("init_busy", busy, 1);
    idle(40);
    chk("init_done", busy, 0);
    view(5'd5, v);
    chk("init_cell5", v, 8'h20);

    lcd_wr(0, 8'h38); idle(BC + 5);
    lcd_wr(0, 8'h0C); idle(BC + 5);
    lcd_wr(0, 8'h06); idle(BC + 5);
    chk("disp_on", disp_on, 1);
    chk("setup_ac", ddram_addr, 0);
    chk("setup_err", err, 0);

    lcd_wr(0, 8'h80); idle(BC + 5);
    lcd_wr(1, 8'h48); idle(BC + 5);
    lcd_wr(1, 8'h49); idle(BC + 5);
    view(5'd0, v); chk("cell0_H", v, 8'h48);
    view(5'd1, v); chk("cell1_I", v, 8'h49);
    chk("ac_after_HI", ddram_addr, 7'h02);

    lcd_wr(0, 8'hA7); idle(BC + 5);
    chk("ac_27", ddram_addr, 7'h27);
    lcd_wr(1, 8'h41); idle(BC + 5);
    chk("ac_wrap_40", ddram_addr, 7'h40);
    view(5'd16, v); chk("cell16_untouched", v, 8'h20);
    lcd_wr(1, 8'h42); idle(BC + 5);
    view(5'd16, v); chk("cell16_B", v, 8'h42);
    lcd_rd(0, v, oe);
    chk("status_41", v, 8'h41);

    lcd_wr(0, 8'h01);
    idle(CC - 20);
    lcd_rd(0, v, oe);
    chk("clear_busy_bit", v[7], 1);
    idle(20);
    lcd_rd(0, v, oe);
    chk("clear_status", v, 8'h00);
    for (int i = 0; i < 32; i++) begin
      view(5'(i), v);
      chk("clear_cell", v, 8'h20);
    end

    lcd_wr(1, 8'h55);
    lcd_wr(1, 8'h66);
    idle(BC + 5);
    chk("busy_write_err", err, 1);
    chk("busy_write_ac", ddram_addr, 7'h01);
    view(5'd1, v); chk("busy_write_drop", v, 8'h20);
    view(5'd0, v); chk("first_write", v, 8'h55);
    lcd_wr(0, 8'h06); idle(BC + 5);
    chk("err_sticky", err, 1);

    lcd_wr(0, 8'h04); idle(BC + 5);
    lcd_wr(0, 8'h80); idle(BC + 5);
    lcd_rd(1, v, oe);
    chk("rd_oe", oe, 1);
    chk("rd_data", v, 8'h55);
    chk("rd_ac_wrap", ddram_addr, 7'h67);
    chk("rd_oe_low", bus.lcd_DATA_oe, 0);
    chk("rd_no_busy", busy, 0);

    lcd_wr(0, 8'h01);
    idle(10);
    rst_n = 1'b0;
    #2;
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    chk("abort_ac", ddram_addr, 0);
    idle(2);
    rst_n = 1'b1;
    idle(40);
    view(5'd0, v); chk("reinit_cell0", v, 8'h20);
    chk("reinit_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
